alu_seq: RTL

Sequential execute-stage ALU that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code plus two 32-bit operands and produces a registered result and zero flag. Single-cycle operations complete in one cycle. MUL uses an iterative shift-add multiplier that raises a busy/stall signal toward the hazard logic until the product is ready.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Execute-stage ALU with registered result. Every operation except MUL
// completes with a latency of one cycle. MUL uses an iterative shift-add
// multiplier that takes 32 cycles and raises busy_o while it runs.
//
// Build option:
//   ALU_FAST_MUL_EN  when defined, MUL is a one-cycle registered multiply,
//                    the MUL state is never entered and busy_o stays 0.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-low reset
//   valid_i    operation request, only looked at while busy_o=0
//   flush_i    abort any pending or requested operation
//   ALUCtrl_i  4-bit operation code from the ALU control decoder
//   data1_i    operand A
//   data2_i    operand B
//   data_o     registered result
//   zero_o     registered (result == 0) flag, updated together with data_o
//   done_o     one-cycle pulse marking a new data_o/zero_o
//   busy_o     multiplier iterating, upstream must stall
//
// State    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | accepting requests; single-cycle ops retire here
// S_MUL    | shift-add multiply in progress, one bit of B per cycle
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        zero_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SRAI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic        zero_q;
    logic        done_q;
    logic        busy_q;
    logic [31:0] alu_res_d;

    // Result of the single-cycle datapath for the op currently presented.
    always_comb begin
        alu_res_d = '0;
        case (ALUCtrl_i)
            OP_AND:                alu_res_d = data1_i & data2_i;
            OP_XOR:                alu_res_d = data1_i ^ data2_i;
            OP_SLL:                alu_res_d = data1_i << data2_i[4:0];
            OP_ADD, OP_ADDI,
            OP_LW, OP_SW:          alu_res_d = data1_i + data2_i;
            OP_SUB, OP_BEQ:        alu_res_d = data1_i - data2_i;
            OP_SRAI:               alu_res_d = $signed(data1_i) >>> data2_i[4:0];
`ifdef ALU_FAST_MUL_EN
            OP_MUL:                alu_res_d = data1_i * data2_i;
`endif
            default:               alu_res_d = '0;
        endcase
    end

`ifdef ALU_FAST_MUL_EN

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (valid_i && !flush_i) begin
                data_q <= alu_res_d;
                zero_q <= (alu_res_d == 32'd0);
                done_q <= 1'b1;
            end
        end
    end

`else

    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_d;

    // Accumulator value after the current iteration; also the final product
    // on the last iteration, so the result is written straight from here.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_i && !flush_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand_q  <= data1_i;
                            mplier_q <= data2_i;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            data_q <= alu_res_d;
                            zero_q <= (alu_res_d == 32'd0);
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            data_q  <= acc_d;
                            zero_q  <= (acc_d == 32'd0);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`endif

    assign data_o = data_q;
    assign zero_o = zero_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule
